// File: rtl/rand_range.sv
// Uniform value source: accepts unbiased LFSR bytes, reduces them modulo RANGE
// with a serial restoring divider, and queues the results behind valid/ready.
module rand_range #(
    parameter int RANGE = 6,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic [7:0]  rnd_in,
    input  logic        rnd_done,
    output logic [7:0]  val,
    output logic        val_valid,
    input  logic        val_ready,
    output logic [15:0] reject_cnt,
    output logic        overrun
);

    localparam int          PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0]  LIMIT      = 9'(256 - (256 % RANGE));
    localparam logic [8:0]  MODULUS    = 9'(RANGE);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        HOLD
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    pend_reg;
    logic          pend_valid_reg;
    logic [7:0]    dividend_reg;
    logic [8:0]    rem_reg;
    logic [2:0]    step_reg;
    logic [7:0]    hold_reg;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic [15:0]   reject_reg;
    logic          overrun_reg;

    logic [8:0]    rem_shift, rem_step;
    logic          fifo_full, pop, push, take_pend, park;
    logic [7:0]    push_data;
    logic          in_range, accept, reject;

    // Bytes at or above LIMIT would over-represent the low residues.
    assign in_range = ({1'b0, rnd_in} < LIMIT);
    assign accept   = rnd_done && in_range;
    assign reject   = rnd_done && !in_range;

    // rem_reg never exceeds RANGE-1, so dropping its top bit on the shift is exact.
    assign rem_shift = 9'({rem_reg, dividend_reg[7]});
    assign rem_step  = (rem_shift >= MODULUS) ? (rem_shift - MODULUS) : rem_shift;

    assign fifo_full  = (count_reg == FULL_COUNT);
    assign val_valid  = (count_reg != '0);
    assign pop        = val_valid && val_ready;
    assign val        = mem[rd_ptr_reg];
    assign reject_cnt = reject_reg;
    assign overrun    = overrun_reg;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        push_data  = rem_step[7:0];
        take_pend  = 1'b0;
        park       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pend_valid_reg) begin
                    take_pend  = 1'b1;
                    state_next = DIV;
                end
            end
            DIV: begin
                if (step_reg == 3'd7) begin
                    if (!fifo_full) begin
                        push = 1'b1;
                        if (pend_valid_reg) begin
                            take_pend  = 1'b1;
                            state_next = DIV;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        park       = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                push_data = hold_reg;
                if (!fifo_full) begin
                    push = 1'b1;
                    if (pend_valid_reg) begin
                        take_pend  = 1'b1;
                        state_next = DIV;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_reg      <= IDLE;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            dividend_reg   <= '0;
            rem_reg        <= '0;
            step_reg       <= '0;
            hold_reg       <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            reject_reg     <= '0;
            overrun_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (take_pend) begin
                dividend_reg <= pend_reg;
                rem_reg      <= '0;
                step_reg     <= '0;
            end else if (state_reg == DIV) begin
                dividend_reg <= {dividend_reg[6:0], 1'b0};
                rem_reg      <= rem_step;
                step_reg     <= step_reg + 3'd1;
            end

            if (park) begin
                hold_reg <= rem_step[7:0];
            end

            // A byte arriving as the engine drains pend slips in without loss.
            if (accept) begin
                if (!pend_valid_reg || take_pend) begin
                    pend_reg       <= rnd_in;
                    pend_valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (take_pend) begin
                pend_valid_reg <= 1'b0;
            end

            if (reject && (reject_reg != 16'hFFFF)) begin
                reject_reg <= reject_reg + 16'd1;
            end

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: tb/tb_rand_range.sv
// Directed bench for rand_range: an expected-result queue model checked every
// cycle, plus literal latency/value checks for each scenario.
module tb_rand_range;

    localparam int RANGE_T = 6;
    localparam int LIMIT_T = 256 - (256 % RANGE_T);

    logic        clk = 1'b0;
    logic        res_n;
    logic [7:0]  rnd_in;
    logic        rnd_done;
    logic [7:0]  val;
    logic        val_valid;
    logic        val_ready;
    logic [15:0] reject_cnt;
    logic        overrun;

    logic [7:0]  rnd_in8;
    logic        rnd_done8;
    logic [7:0]  val8;
    logic        val_valid8;
    logic        val_ready8;
    logic [15:0] reject_cnt8;
    logic        overrun8;

    always #5 clk = ~clk;

    rand_range #(.RANGE(RANGE_T), .DEPTH(4)) dut (
        .clk(clk), .res_n(res_n), .rnd_in(rnd_in), .rnd_done(rnd_done),
        .val(val), .val_valid(val_valid), .val_ready(val_ready),
        .reject_cnt(reject_cnt), .overrun(overrun)
    );

    rand_range #(.RANGE(8), .DEPTH(4)) dut8 (
        .clk(clk), .res_n(res_n), .rnd_in(rnd_in8), .rnd_done(rnd_done8),
        .val(val8), .val_valid(val_valid8), .val_ready(val_ready8),
        .reject_cnt(reject_cnt8), .overrun(overrun8)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   exp_q[$];
    int   exp_rej = 0;
    logic exp_ovr = 1'b0;
    logic tb_lost = 1'b0;   // stimulus marks a byte the scenario expects to be lost

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Model: each accepted byte yields byte % RANGE, in order; rejects count up.
    always begin : model_and_compare
        @(posedge clk);
        if (!res_n) begin
            exp_q.delete();
            exp_rej = 0;
            exp_ovr = 1'b0;
        end else if (rnd_done) begin
            if (int'(rnd_in) >= LIMIT_T) begin
                if (exp_rej < 65535) exp_rej++;
            end else if (tb_lost) begin
                exp_ovr = 1'b1;
            end else begin
                exp_q.push_back(int'(rnd_in) % RANGE_T);
            end
        end
        @(negedge clk);
        #1;
        check("reject_cnt", {16'd0, reject_cnt}, exp_rej);
        check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        if (res_n && val_valid && val_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got val=%0d required no output", val);
            end else begin
                $display("pop val=%0d", val);
                check("val_order", {24'd0, val}, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [7:0] b, input logic lost);
        rnd_in   = b;
        rnd_done = 1'b1;
        tb_lost  = lost;
        @(negedge clk);
        rnd_done = 1'b0;
        tb_lost  = 1'b0;
    endtask

    task automatic do_reset();
        res_n = 1'b0;
        @(negedge clk);
        res_n = 1'b1;
    endtask

    initial begin
        res_n      = 1'b0;
        rnd_in     = 8'h11;
        rnd_done   = 1'b1;
        val_ready  = 1'b1;
        rnd_in8    = 8'h00;
        rnd_done8  = 1'b0;
        val_ready8 = 1'b0;

        // Reset held two edges with strobes present
        @(negedge clk);
        rnd_in = 8'hFC;
        @(negedge clk);
        check("rst_valid", {31'd0, val_valid}, 0);
        check("rst_reject", {16'd0, reject_cnt}, 0);
        check("rst_overrun", {31'd0, overrun}, 0);
        res_n    = 1'b1;
        rnd_done = 1'b0;
        cyc(12);
        check("rst_no_output", {31'd0, val_valid}, 0);

        // Basic latency: 0x11 % 6 = 5
        strobe(8'h11, 1'b0);
        cyc(8);
        check("basic_e8_valid", {31'd0, val_valid}, 0);
        cyc(1);
        check("basic_e9_valid", {31'd0, val_valid}, 1);
        check("basic_val", {24'd0, val}, 5);
        cyc(1);
        check("basic_drop", {31'd0, val_valid}, 0);

        // Rejection: 0xFC dropped, 0xFB -> 251 % 6 = 5
        strobe(8'hFC, 1'b0);
        strobe(8'hFB, 1'b0);
        cyc(8);
        check("rej_e8_valid", {31'd0, val_valid}, 0);
        cyc(1);
        check("rej_valid", {31'd0, val_valid}, 1);
        check("rej_val", {24'd0, val}, 5);
        check("rej_count", {16'd0, reject_cnt}, 1);
        cyc(3);
        check("rej_single", {31'd0, val_valid}, 0);

        // RANGE=8: 0xFF accepted -> 7
        rnd_in8   = 8'hFF;
        rnd_done8 = 1'b1;
        @(negedge clk);
        rnd_done8 = 1'b0;
        cyc(8);
        check("r8_e8_valid", {31'd0, val_valid8}, 0);
        cyc(1);
        check("r8_valid", {31'd0, val_valid8}, 1);
        check("r8_val", {24'd0, val8}, 7);
        check("r8_reject", {16'd0, reject_cnt8}, 0);
        check("r8_overrun", {31'd0, overrun8}, 0);

        // Backpressure: FIFO 0..3, 4 in HOLD, 5 in pend, 6 lost
        val_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 6) check("bp_no_overrun_yet", {31'd0, overrun}, 0);
            strobe(8'(i), i == 6);
            cyc(7);
        end
        check("bp_overrun", {31'd0, overrun}, 1);
        check("bp_head", {24'd0, val}, 0);
        val_ready = 1'b1;
        cyc(30);
        check("bp_drained", {31'd0, val_valid}, 0);

        // Strobe collision at E0/E1: 0x20 -> 2, 0x31 -> 1, 8 cycles apart
        do_reset();
        strobe(8'h20, 1'b0);
        strobe(8'h31, 1'b0);
        check("col_no_overrun", {31'd0, overrun}, 0);
        cyc(8);
        check("col_first_valid", {31'd0, val_valid}, 1);
        check("col_first_val", {24'd0, val}, 2);
        cyc(7);
        check("col_gap", {31'd0, val_valid}, 0);
        cyc(1);
        check("col_second_valid", {31'd0, val_valid}, 1);
        check("col_second_val", {24'd0, val}, 1);
        cyc(3);

        // Third strobe at E2 is lost
        do_reset();
        strobe(8'h05, 1'b0);
        strobe(8'h07, 1'b0);
        strobe(8'h09, 1'b1);
        check("col3_overrun", {31'd0, overrun}, 1);
        cyc(25);
        check("col3_drained", {31'd0, val_valid}, 0);

        // Reset on the edge of DIV step 4 abandons the byte
        do_reset();
        strobe(8'h40, 1'b0);
        cyc(5);
        do_reset();
        cyc(12);
        check("mid_no_output", {31'd0, val_valid}, 0);
        strobe(8'h22, 1'b0);
        cyc(8);
        check("mid_e8_valid", {31'd0, val_valid}, 0);
        cyc(1);
        check("mid_valid", {31'd0, val_valid}, 1);
        check("mid_val", {24'd0, val}, 4);
        cyc(3);

        check("model_queue_empty", exp_q.size(), 0);
        check("final_valid", {31'd0, val_valid}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rand_range.md
# rand_range

Downstream consumer of the 8-bit LFSR byte generator. Samples each byte on the generator's one-cycle `done` strobe, discards bytes that would bias the result, reduces the accepted bytes modulo `RANGE` with an 8-step restoring divider, and buffers the results in a small FIFO. The FIFO drains through a valid/ready handshake, so game or test logic can draw uniform values in 0..RANGE-1 at its own pace.

## Interface
- `RANGE`, default 6: modulus, legal 2..255.
- `DEPTH`, default 4: result FIFO entries, power of two, 2..16.
- `clk`  in  1: sole clock, rising edge.
- `res_n`  in  1: synchronous, active-low reset.
- `rnd_in`  in  8: random byte from the generator.
- `rnd_done`  in  1: one-cycle strobe; `rnd_in` is valid while it is high.
- `val`  out  8: FIFO head, range 0..RANGE-1.
- `val_valid`  out  1: FIFO not empty.
- `val_ready`  in  1: consumer accepts `val` on this edge.
- `reject_cnt`  out  16: count of rejected bytes, saturates at 0xFFFF.
- `overrun`  out  1: sticky flag; an accepted byte was lost.

## Operation
- LIMIT = 256 - (256 mod RANGE), a compile-time constant.
- Capture, on an edge with `rnd_done`=1:
  - `rnd_in` >= LIMIT: byte dropped, `reject_cnt` +1 (saturating).
  - Otherwise the byte goes into the one-entry holding register `pend`.
  - If `pend` is already full and the engine does not take it on the same edge, the new byte is lost and `overrun` is set to 1.
- Engine states:
  - IDLE: if `pend` is valid, load the dividend from `pend`, clear the remainder, set step=0, clear `pend`, go to DIV.
  - DIV: one restoring step per cycle.
    - r = {r[7:0], dividend msb}; dividend shifts left.
    - If r >= RANGE, then r -= RANGE.
    - The remainder register is 9 bits.
  - End of DIV (step 7): the final remainder is pushed into the FIFO on the same edge, provided the FIFO is not full.
    - Then, if `pend` is valid, load it and stay in DIV at step 0 (no bubble). Otherwise go to IDLE.
    - If the FIFO is full, store the remainder and go to HOLD.
  - HOLD: push on the first edge where the FIFO count < DEPTH, then apply the same `pend`/IDLE decision as the end of DIV.
- Push and pop:
  - Push only while the count < DEPTH. There is no pass-through on a simultaneous pop when full.
  - Pop when `val_valid`=1 and `val_ready`=1.
  - Push and pop on the same edge leaves the count unchanged.
  - Pointers wrap modulo DEPTH. Results leave in arrival order.
- Reset (`res_n`=0 at an edge):
  - Clears state to IDLE, `pend`, dividend, remainder, step, FIFO pointers and count, `reject_cnt` and `overrun`.
  - FIFO contents are discarded.
  - `rnd_done` is ignored on reset edges.
  - Reset mid-division abandons that byte; it is never output.

## Timing
- Reset values: `val_valid`=0, `reject_cnt`=0, `overrun`=0. `val` is don't-care while `val_valid`=0.
- Latency from an idle engine:
  - E0: `rnd_done` is sampled and `pend` is filled.
  - E1: the engine loads.
  - E2..E9: the eight DIV steps.
  - The result is written at E9, and `val_valid`=1 after E9 (9 edges).
- Throughput: one result per 8 cycles when `pend` is refilled in time. This matches the generator's 8-cycle `done` cadence.
- `val` and `val_valid` come from registered state only. There is no combinational path from `val_ready` to `val_valid`.
- An accepted byte arriving on the same edge the engine takes `pend` is captured without overrun.

## Test plan
- Reset: hold `res_n`=0 for 2 cycles, with `rnd_done` pulses during reset.
  - Required: `val_valid`=0, `reject_cnt`=0, `overrun`=0, and no output afterwards.
- Basic, RANGE=6: `rnd_in`=0x11 with `rnd_done` at E0, `val_ready`=1.
  - Required: `val_valid` rises after E9 with `val`=5, and drops the edge after the pop.
- Rejection, RANGE=6: send 0xFC, then 0xFB.
  - Required: `reject_cnt`=1, no output for 0xFC; a single output `val`=5 for 0xFB.
  - With RANGE=8, 0xFF is accepted (`val`=7) and `reject_cnt` stays 0.
- Backpressure, DEPTH=4, `val_ready`=0: bytes 0,1,2,3,4,5,6 at 8-cycle spacing, RANGE=6.
  - Required: the FIFO holds 0,1,2,3; 4 waits in HOLD; 5 waits in `pend`; the 7th byte sets `overrun`=1.
  - Then `val_ready`=1 drains 0,1,2,3,4,5 in order.
- Strobe collision: `rnd_done` at E0 and E1 from idle.
  - Required: no overrun; results from both bytes appear 8 cycles apart.
  - A third strobe at E2 sets `overrun`=1.
- Reset mid-op: assert `res_n`=0 for one edge during DIV step 4.
  - Required: no output appears from the abandoned byte; the next byte completes with normal 9-edge latency.
